instr_encoder: RTL and testbench

Packs a bundle of RV64IM instruction fields (opcode, funct3, funct7, register indices, 32-bit immediate) into the 32-bit RISC-V instruction word, which is the reverse of the instruction decoder. It sits in the test and stimulus path ahead of the fetch and decode stage, for example as the back end of the self-checking instruction generator. Encoded words are buffered in a small FIFO with valid/ready handshakes on both sides. Illegal field bundles are flagged rather than dropped.

---
 rtl/instr_encoder_if.sv | 34 +++
 rtl/instr_encoder.sv | 149 ++++++++++++++
 tb/tb_instr_encoder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle input and encoded-word output handshakes for instr_encoder.
//   master: the producer/consumer side (drives the field bundle and out_ready)
//   slave : the encoder side (drives in_ready and the FIFO head)
//   in_*  : field bundle with valid/ready
//   out_* : encoded word at the FIFO head with valid/ready and an illegal flag
interface instr_encoder_if #(
  parameter int unsigned INSTRSZ = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [6:0]         in_opcode;
  logic [2:0]         in_funct3;
  logic [6:0]         in_funct7;
  logic [4:0]         in_rd;
  logic [4:0]         in_rs1;
  logic [4:0]         in_rs2;
  logic [31:0]        in_imm;
  logic               out_valid;
  logic               out_ready;
  logic [INSTRSZ-1:0] out_instr;
  logic               out_illegal;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_illegal
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV64IM instruction fields into a 32-bit instruction word and buffers the
// result in a DEPTH-entry FIFO. Illegal bundles are stored as a zero word with an illegal flag.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset, clears FIFO and enc_count
//   bus       : instr_encoder_if slave (field bundle in, encoded word out)
//   enc_count : number of legal words accepted since reset (wraps)
module instr_encoder #(
  parameter int unsigned INSTRSZ = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_encoder_if.slave     bus,
  output logic [31:0]        enc_count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpImm32   = 7'b0011011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpOp32    = 7'b0111011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  logic [INSTRSZ-1:0] enc_word;
  logic               enc_illegal;
  logic               is_shift;

  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [31:0]        enc_count_q, enc_count_d;
  logic [INSTRSZ:0]   mem_q [DEPTH];
  logic [INSTRSZ:0]   head;
  logic               full, empty, push, pop;

  // Field packing
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    is_shift    = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);
    case (bus.in_opcode)
      OpOp, OpOp32: begin
        enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                    bus.in_opcode};
      end
      OpLoad, OpMiscMem, OpJalr, OpSystem: begin
        enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      end
      OpImm: begin
        if (is_shift) begin
          // 64-bit shifts take a 6-bit shamt; funct7[0] is displaced by shamt[5]
          enc_word = {bus.in_funct7[6:1], bus.in_imm[5:0], bus.in_rs1, bus.in_funct3,
                      bus.in_rd, bus.in_opcode};
        end else begin
          enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        end
      end
      OpImm32: begin
        if (is_shift) begin
          enc_word = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                      bus.in_opcode};
        end else begin
          enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        end
      end
      OpStore: begin
        enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:0],
                    bus.in_opcode};
      end
      OpBranch: begin
        enc_illegal = bus.in_imm[0] || (bus.in_funct3 == 3'b010) || (bus.in_funct3 == 3'b011);
        enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
      end
      OpLui, OpAuipc: begin
        enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
      end
      OpJal: begin
        enc_illegal = bus.in_imm[0];
        enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                    bus.in_rd, bus.in_opcode};
      end
      default: enc_illegal = 1'b1;
    endcase
    if (enc_illegal) begin
      enc_word = '0;
    end
  end

  // FIFO control: extra pointer MSB distinguishes full from empty
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
            (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    push  = bus.in_valid && !full;
    pop   = !empty && bus.out_ready;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    enc_count_d = enc_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (!enc_illegal) begin
        enc_count_d = enc_count_q + 32'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      enc_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      enc_count_q <= enc_count_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= {enc_illegal, enc_word};
    end
  end

  always_comb begin
    head            = mem_q[rd_ptr_q[AddrW-1:0]];
    bus.in_ready    = !full;
    bus.out_valid   = !empty;
    bus.out_instr   = empty ? '0   : head[INSTRSZ-1:0];
    bus.out_illegal = empty ? 1'b0 : head[INSTRSZ];
    enc_count       = enc_count_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] enc_count;

  instr_encoder_if #(.INSTRSZ(32)) bus ();

  instr_encoder #(.INSTRSZ(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  int unsigned   n_pass = 0;
  int unsigned   n_chk  = 0;
  logic [32:0]   exp_q[$];
  logic [32:0]   cur_exp;
  logic [31:0]   exp_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] put(input logic [31:0] v, input int pos);
    return v << pos;
  endfunction

  function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference encoder: places each field at its bit position in the instruction word
  function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] base;
    bit          ill;
    bit          sh;
    ill  = 0;
    sh   = (f3 == 3'd1) || (f3 == 3'd5);
    base = put(op, 0) | put(f3, 12) | put(rs1, 15);
    case (op)
      7'b0110011, 7'b0111011: w = base | put(rd, 7) | put(rs2, 20) | put(f7, 25);
      7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011:
        w = base | put(rd, 7) | put(bits(imm, 11, 0), 20);
      7'b0010011:
        if (sh) w = base | put(rd, 7) | put(bits(imm, 5, 0), 20) | put(32'(f7) >> 1, 26);
        else    w = base | put(rd, 7) | put(bits(imm, 11, 0), 20);
      7'b0011011:
        if (sh) w = base | put(rd, 7) | put(bits(imm, 4, 0), 20) | put(f7, 25);
        else    w = base | put(rd, 7) | put(bits(imm, 11, 0), 20);
      7'b0100011: w = base | put(bits(imm, 4, 0), 7) | put(rs2, 20) | put(bits(imm, 11, 5), 25);
      7'b1100011: begin
        ill = imm[0] || f3 == 3'd2 || f3 == 3'd3;
        w = base | put(bits(imm, 11, 11), 7) | put(bits(imm, 4, 1), 8) | put(rs2, 20) |
            put(bits(imm, 10, 5), 25) | put(bits(imm, 12, 12), 31);
      end
      7'b0110111, 7'b0010111: w = put(op, 0) | put(rd, 7) | (imm & 32'hFFFF_F000);
      7'b1101111: begin
        ill = imm[0];
        w = put(op, 0) | put(rd, 7) | put(bits(imm, 19, 12), 12) | put(bits(imm, 11, 11), 20) |
            put(bits(imm, 10, 1), 21) | put(bits(imm, 20, 20), 31);
      end
      default: begin ill = 1; w = 0; end
    endcase
    if (ill) w = 0;
    return {ill, w};
  endfunction

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
    bus.in_opcode = op;  bus.in_funct3 = f3; bus.in_funct7 = f7;
    bus.in_rd = rd;      bus.in_rs1 = rs1;   bus.in_rs2 = rs2;  bus.in_imm = imm;
    cur_exp = ref_enc(op, f3, f7, rd, rs1, rs2, imm);
  endtask

  task automatic set_random();
    logic [6:0] ops [13];
    logic [31:0] imm;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h63, 7'h67,
            7'h6F, 7'h73};
    imm = $urandom;
    if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
    set_in(($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 12)],
           3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
  endtask

  // One clock cycle; records the bundle in the scoreboard if the DUT accepted it
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back(cur_exp);
      if (!cur_exp[32]) exp_count++;
    end
    #1;
  endtask

  task automatic send();
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    n = 0;
    do begin tick(acc); n++; end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_dir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input logic ill, input logic [31:0] word);
    set_in(op, f3, f7, rd, rs1, rs2, imm);
    cur_exp = {ill, word};
    send();
  endtask

  task automatic drain();
    bit acc;
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(acc); n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: compares FIFO head against the scoreboard and pops on handshake
  initial begin
    logic [32:0] head;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        chk("in_ready", bus.in_ready, exp_q.size() < DEPTH);
        chk("enc_count", enc_count, exp_count);
        if (bus.out_valid && exp_q.size() != 0) begin
          head = exp_q[0];
          chk("out_word", {bus.out_illegal, bus.out_instr}, head);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_illegal", bus.out_illegal, 0);
    chk("rst_enc_count", enc_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known encodings
    bus.out_ready = 1'b1;
    send_dir(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 32'h002081B3);
    send_dir(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 0, 32'hFFF00093);
    send_dir(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0, 32'h0020A423);
    send_dir(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 0, 32'h123452B7);
    send_dir(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 0, 32'hFE208EE3);
    send_dir(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 0, 32'h001000EF);
    send_dir(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h801, 1, 32'h0);
    send_dir(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0, 1, 32'h0);
    send_dir(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 32'h002081B3);
    drain();

    // Backpressure: four fill the FIFO, fifth waits for the first pop
    bus.out_ready = 1'b0;
    repeat (4) begin set_random(); send(); end
    set_random();
    bus.in_valid = 1'b1;
    tick(acc); chk("fifth_held", acc, 0);
    bus.out_ready = 1'b1;
    tick(acc); chk("fifth_held_at_pop", acc, 0);
    tick(acc); chk("fifth_after_pop", acc, 1);
    bus.in_valid = 1'b0;
    drain();

    // Simultaneous push/pop at occupancy 2
    bus.out_ready = 1'b0;
    repeat (2) begin set_random(); send(); end
    bus.out_ready = 1'b1;
    set_random();
    bus.in_valid = 1'b1;
    tick(acc); chk("push_pop_accept", acc, 1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) begin set_random(); send(); end
    @(negedge clk);
    chk("occ_full_after_pushpop", bus.in_ready, 0);
    @(posedge clk); #1;
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_random();
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick(acc);
    end
    bus.in_valid = 1'b0;
    drain();

    // Asynchronous reset with entries pending
    bus.out_ready = 1'b0;
    repeat (3) begin set_random(); send(); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_out_instr", bus.out_instr, 0);
    chk("async_rst_enc_count", enc_count, 0);
    chk("async_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    exp_count = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_dir(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 0, 32'hFFF00093);
    @(negedge clk);
    chk("post_rst_head", {bus.out_illegal, bus.out_instr}, {1'b0, 32'hFFF00093});
    @(posedge clk); #1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
